base_split: RTL and testbench

// - Inverse of the lane summer: takes one total value and splits it into a stream of n-lane beats.
// - Each lane carries at most LMAX = 2**iw-1; lanes fill greedily, lane 0 first.
// - Summing every emitted lane over every beat of one transfer gives back the input total exactly.
// - Sits ahead of credit/length consumers that take n packed iw-bit lanes per cycle.

---
 rtl/base_split.sv | 112 +++++++++++
 tb/tb_base_split.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/base_split.sv
// Splits one ow-bit total into a stream of n-lane beats, each lane at most 2**iw-1, lane 0 filled first.
// Optional macro BASE_SPLIT_ZERO_BEAT_EN: a zero total yields one all-zero last beat instead of no beat.
module base_split #(
    parameter int n  = 1,
    parameter int iw = 1,
    parameter int ow = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_v,
    output logic              i_r,
    input  logic [0:ow-1]     i_d,
    output logic              o_v,
    input  logic              o_r,
    output logic [0:n*iw-1]   o_d,
    output logic              o_last
);

    localparam int unsigned     LMAX   = (1 << iw) - 1;
    localparam longint unsigned NLMAX  = longint'(n) * longint'(LMAX);
    localparam int              CW_MIN = $clog2(NLMAX + 1);
    localparam int              CW     = (ow > CW_MIN) ? ow : CW_MIN;

    localparam logic [ow-1:0] LMAX_OW  = ow'(LMAX);
    localparam logic [CW-1:0] NLMAX_CW = CW'(NLMAX);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t         state_reg;
    logic [ow-1:0]  rem_reg;
    logic [ow-1:0]  rem_next;
    logic [ow-1:0]  in_total;
    logic [CW-1:0]  rem_cw;
    logic [0:n*iw-1] beat_d;
    logic [ow-1:0]  avail;
    logic [ow-1:0]  lane_w;
    logic           accept;
    logic           beat_xfer;
    logic           load_busy;

    // Positional assignment keeps the MSB-first input as an ordinary number.
    assign in_total = i_d;
    assign rem_cw   = CW'(rem_reg);

    // Greedy fill: each lane takes min(what is left, LMAX); whatever survives is the next remainder.
    always_comb begin
        avail  = rem_reg;
        lane_w = '0;
        beat_d = '0;
        for (int j = 0; j < n; j++) begin
            lane_w = (avail > LMAX_OW) ? LMAX_OW : avail;
            beat_d[j*iw +: iw] = lane_w[iw-1:0];
            avail  = avail - lane_w;
        end
        rem_next = avail;
    end

    assign o_v    = (state_reg == BUSY);
    assign o_last = o_v && (rem_cw <= NLMAX_CW);

    generate
        for (genvar gi = 0; gi < n; gi++) begin : g_lane
            assign o_d[gi*iw +: iw] = o_v ? beat_d[gi*iw +: iw] : '0;
        end
    endgenerate

    assign i_r       = !reset && ((state_reg == IDLE) || (o_v && o_r && o_last));
    assign accept    = i_v && i_r;
    assign beat_xfer = o_v && o_r;

`ifdef BASE_SPLIT_ZERO_BEAT_EN
    assign load_busy = 1'b1;
`else
    // A zero total is swallowed: it is accepted but never reaches BUSY.
    assign load_busy = (in_total != '0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        rem_reg   <= in_total;
                        state_reg <= load_busy ? BUSY : IDLE;
                    end
                end
                BUSY: begin
                    if (beat_xfer) begin
                        if (accept) begin
                            rem_reg   <= in_total;
                            state_reg <= load_busy ? BUSY : IDLE;
                        end else begin
                            rem_reg   <= rem_next;
                            state_reg <= o_last ? IDLE : BUSY;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    rem_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_base_split.sv
// Directed bench for base_split with n=4, iw=4 (LMAX=15), ow=8; table of totals plus hand-written corner sequences.
module tb_base_split;

    logic        clk;
    logic        reset;
    logic        i_v;
    logic        i_r;
    logic [0:7]  i_d;
    logic        o_v;
    logic        o_r;
    logic [0:15] o_d;
    logic        o_last;

    int tests;
    int fails;

    base_split #(.n(4), .iw(4), .ow(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .i_v    (i_v),
        .i_r    (i_r),
        .i_d    (i_d),
        .o_v    (o_v),
        .o_r    (o_r),
        .o_d    (o_d),
        .o_last (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       total;
        int               nb;
        logic [0:4][15:0] beats;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lanes read left to right: lane 0 is the top nibble of the 16-bit word.
    function automatic logic [15:0] lanes();
        logic [15:0] v;
        v = o_d;
        return v;
    endfunction

    task automatic run_total(input logic [7:0] total, input int nb,
                             input logic [0:4][15:0] exp, input string tag);
        step();
        i_v = 1'b1;
        i_d = total;
        o_r = 1'b1;
        @(negedge clk);
        chk({tag, " i_r"}, 32'(i_r), 32'd1);
        step();
        i_v = 1'b0;
        i_d = 8'($urandom);
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            chk($sformatf("%s beat%0d o_v", tag, b), 32'(o_v), 32'd1);
            chk($sformatf("%s beat%0d o_d", tag, b), 32'(lanes()), 32'(exp[b]));
            chk($sformatf("%s beat%0d o_last", tag, b), 32'(o_last), 32'(b == nb - 1));
        end
        @(negedge clk);
        chk({tag, " idle o_v"}, 32'(o_v), 32'd0);
        $display("[TB] total %0d: %0d beat(s) checked", total, nb);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        i_v   = 1'b0;
        i_d   = '0;
        o_r   = 1'b0;

        vecs[0] = '{8'd37,  1, '{16'hFF70, 16'h0, 16'h0, 16'h0, 16'h0}};
        vecs[1] = '{8'd100, 2, '{16'hFFFF, 16'hFFA0, 16'h0, 16'h0, 16'h0}};
        vecs[2] = '{8'd120, 2, '{16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 16'h0}};
        vecs[3] = '{8'd255, 5, '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hF000}};
        vecs[4] = '{8'd60,  1, '{16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0}};
        vecs[5] = '{8'd1,   1, '{16'h1000, 16'h0, 16'h0, 16'h0, 16'h0}};
        vecs[6] = '{8'd61,  2, '{16'hFFFF, 16'h1000, 16'h0, 16'h0, 16'h0}};

        // Reset state
        @(negedge clk);
        chk("reset i_r", 32'(i_r), 32'd0);
        step();
        @(negedge clk);
        chk("reset o_v", 32'(o_v), 32'd0);
        chk("reset o_last", 32'(o_last), 32'd0);
        chk("reset o_d", 32'(lanes()), 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset i_r", 32'(i_r), 32'd1);
        $display("[TB] reset sequence checked");

        for (int i = 0; i < 7; i++)
            run_total(vecs[i].total, vecs[i].nb, vecs[i].beats, $sformatf("vec%0d", i));

        // Backpressure on the first beat of an exact multiple
        step();
        i_v = 1'b1;
        i_d = 8'd120;
        o_r = 1'b0;
        @(negedge clk);
        chk("bp accept i_r", 32'(i_r), 32'd1);
        step();
        i_v = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d o_v", k), 32'(o_v), 32'd1);
            chk($sformatf("bp hold%0d o_d", k), 32'(lanes()), 32'hFFFF);
            chk($sformatf("bp hold%0d o_last", k), 32'(o_last), 32'd0);
            chk($sformatf("bp hold%0d i_r", k), 32'(i_r), 32'd0);
        end
        step();
        o_r = 1'b1;
        @(negedge clk);
        chk("bp beat0 o_d", 32'(lanes()), 32'hFFFF);
        chk("bp beat0 o_last", 32'(o_last), 32'd0);
        @(negedge clk);
        chk("bp beat1 o_d", 32'(lanes()), 32'hFFFF);
        chk("bp beat1 o_last", 32'(o_last), 32'd1);
        chk("bp beat1 i_r", 32'(i_r), 32'd1);
        @(negedge clk);
        chk("bp idle o_v", 32'(o_v), 32'd0);
        $display("[TB] backpressure total 120 checked");

        // Back-to-back: second total accepted on the last-beat cycle
        step();
        i_v = 1'b1;
        i_d = 8'd20;
        o_r = 1'b1;
        @(negedge clk);
        chk("b2b accept0 i_r", 32'(i_r), 32'd1);
        step();
        i_d = 8'd5;
        @(negedge clk);
        chk("b2b beat0 o_v", 32'(o_v), 32'd1);
        chk("b2b beat0 o_d", 32'(lanes()), 32'hF500);
        chk("b2b beat0 o_last", 32'(o_last), 32'd1);
        chk("b2b beat0 i_r", 32'(i_r), 32'd1);
        step();
        i_v = 1'b0;
        @(negedge clk);
        chk("b2b beat1 o_v", 32'(o_v), 32'd1);
        chk("b2b beat1 o_d", 32'(lanes()), 32'h5000);
        chk("b2b beat1 o_last", 32'(o_last), 32'd1);
        @(negedge clk);
        chk("b2b idle o_v", 32'(o_v), 32'd0);
        $display("[TB] back-to-back 20 then 5 checked");

        // Zero total
`ifdef BASE_SPLIT_ZERO_BEAT_EN
        run_total(8'd0, 1, '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, "zero");
`else
        step();
        i_v = 1'b1;
        i_d = 8'd0;
        o_r = 1'b1;
        @(negedge clk);
        chk("zero i_r", 32'(i_r), 32'd1);
        step();
        i_v = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("zero no-beat%0d o_v", k), 32'(o_v), 32'd0);
            chk($sformatf("zero no-beat%0d i_r", k), 32'(i_r), 32'd1);
        end
        $display("[TB] zero total produced no beat");
        run_total(8'd16, 1, '{16'hF100, 16'h0, 16'h0, 16'h0, 16'h0}, "after-zero");
`endif

        // Reset mid-transfer
        step();
        i_v = 1'b1;
        i_d = 8'd200;
        o_r = 1'b1;
        @(negedge clk);
        chk("rst accept i_r", 32'(i_r), 32'd1);
        step();
        i_v = 1'b0;
        @(negedge clk);
        chk("rst beat0 o_d", 32'(lanes()), 32'hFFFF);
        chk("rst beat0 o_last", 32'(o_last), 32'd0);
        step();
        o_r   = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst during i_r", 32'(i_r), 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst after o_v", 32'(o_v), 32'd0);
        chk("rst after i_r", 32'(i_r), 32'd1);
        chk("rst after o_d", 32'(lanes()), 32'd0);
        chk("rst after o_last", 32'(o_last), 32'd0);
        $display("[TB] reset mid-transfer checked");
        run_total(8'd3, 1, '{16'h3000, 16'h0, 16'h0, 16'h0, 16'h0}, "post-rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
